// File: rtl/seq_unlock_ctrl.sv
// Sequencing controller: loads a candidate code, clears the serial detector, shifts the code in MSB first and reports pass/fail.
// Optional lockout after MAX_FAIL consecutive failures is enabled by defining SEQ_UNLOCK_LOCKOUT_EN.
module seq_unlock_ctrl #(
  parameter int CODE_W      = 24,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 256,
  parameter int RESP_WIN    = 2
) (
  input  logic                            clk,
  input  logic                            RESET,
  input  logic                            code_valid,
  input  logic [CODE_W-1:0]               code_data,
  output logic                            code_ready,
  output logic                            det_in,
  output logic                            det_rst_n,
  input  logic                            det_out,
  output logic                            done,
  output logic                            pass,
  output logic                            locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int FCW = $clog2(MAX_FAIL + 1);
  localparam int BCW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int WCW = (RESP_WIN > 1) ? $clog2(RESP_WIN) : 1;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
  localparam int LCW = $clog2(LOCK_CYCLES);
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SHIFT   = 3'd2,
    WAIT    = 3'd3,
    REPORT  = 3'd4
`ifdef SEQ_UNLOCK_LOCKOUT_EN
    , LOCKOUT = 3'd5
`endif
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CODE_W-1:0] shift_r, shift_nxt_s;
  logic [BCW-1:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [WCW-1:0]    win_cnt_r, win_cnt_nxt_s;
  logic              spur_r, spur_nxt_s;
  logic              result_r, result_nxt_s;
  logic [FCW-1:0]    fail_cnt_r, fail_cnt_nxt_s;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
  logic [LCW-1:0]    lock_cnt_r, lock_cnt_nxt_s;
`endif
  logic code_ready_r, det_in_r, det_rst_n_r, done_r, pass_r, locked_r;
  logic code_ready_nxt_s, det_in_nxt_s, det_rst_n_nxt_s, done_nxt_s, pass_nxt_s, locked_nxt_s;

  function automatic logic [FCW-1:0] sat_inc(input logic [FCW-1:0] v);
    if (v >= FCW'(MAX_FAIL)) begin
      return FCW'(MAX_FAIL);
    end else begin
      return v + FCW'(1);
    end
  endfunction

  // Next-state, datapath and fail-count update logic
  always_comb begin
    state_nxt_s    = state_r;
    shift_nxt_s    = shift_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    win_cnt_nxt_s  = win_cnt_r;
    spur_nxt_s     = spur_r;
    result_nxt_s   = result_r;
    fail_cnt_nxt_s = fail_cnt_r;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
    lock_cnt_nxt_s = lock_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (code_valid) begin
          shift_nxt_s   = code_data;
          bit_cnt_nxt_s = BCW'(CODE_W - 1);
          spur_nxt_s    = 1'b0;
          result_nxt_s  = 1'b0;
          state_nxt_s   = CLEAR;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      CLEAR: state_nxt_s = SHIFT;
      SHIFT: begin
        // A match while bits are still going in cannot be genuine
        spur_nxt_s  = spur_r | det_out;
        shift_nxt_s = {shift_r[CODE_W-2:0], 1'b0};
        if (bit_cnt_r == BCW'(0)) begin
          win_cnt_nxt_s = WCW'(RESP_WIN - 1);
          state_nxt_s   = WAIT;
        end else begin
          bit_cnt_nxt_s = bit_cnt_r - BCW'(1);
        end
      end
      WAIT: begin
        if (det_out || (win_cnt_r == WCW'(0))) begin
          result_nxt_s = det_out & ~spur_r;
          if (det_out && !spur_r) begin
            fail_cnt_nxt_s = FCW'(0);
          end else begin
            fail_cnt_nxt_s = sat_inc(fail_cnt_r);
          end
          state_nxt_s = REPORT;
        end else begin
          win_cnt_nxt_s = win_cnt_r - WCW'(1);
        end
      end
      REPORT: begin
`ifdef SEQ_UNLOCK_LOCKOUT_EN
        if (!result_r && (fail_cnt_r == FCW'(MAX_FAIL))) begin
          lock_cnt_nxt_s = LCW'(LOCK_CYCLES - 1);
          state_nxt_s    = LOCKOUT;
        end else begin
          state_nxt_s    = IDLE;
        end
`else
        state_nxt_s = IDLE;
`endif
      end
`ifdef SEQ_UNLOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (lock_cnt_r == LCW'(0)) begin
          fail_cnt_nxt_s = FCW'(0);
          state_nxt_s    = IDLE;
        end else begin
          lock_cnt_nxt_s = lock_cnt_r - LCW'(1);
        end
      end
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  assign code_ready_nxt_s = (state_nxt_s == IDLE);
  assign det_in_nxt_s     = (state_nxt_s == SHIFT) & shift_nxt_s[CODE_W-1];
  assign det_rst_n_nxt_s  = (state_nxt_s != CLEAR);
  assign done_nxt_s       = (state_nxt_s == REPORT);
  assign pass_nxt_s       = (state_nxt_s == REPORT) & result_nxt_s;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
  assign locked_nxt_s     = (state_nxt_s == LOCKOUT);
`else
  assign locked_nxt_s     = 1'b0;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_r      <= IDLE;
      shift_r      <= CODE_W'(0);
      bit_cnt_r    <= BCW'(0);
      win_cnt_r    <= WCW'(0);
      spur_r       <= 1'b0;
      result_r     <= 1'b0;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
      lock_cnt_r   <= LCW'(0);
`else
      fail_cnt_r   <= FCW'(0);
`endif
      code_ready_r <= 1'b0;
      det_in_r     <= 1'b0;
      det_rst_n_r  <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shift_r      <= shift_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      win_cnt_r    <= win_cnt_nxt_s;
      spur_r       <= spur_nxt_s;
      result_r     <= result_nxt_s;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
      lock_cnt_r   <= lock_cnt_nxt_s;
`else
      fail_cnt_r   <= fail_cnt_nxt_s;
`endif
      code_ready_r <= code_ready_nxt_s;
      det_in_r     <= det_in_nxt_s;
      det_rst_n_r  <= det_rst_n_nxt_s;
      done_r       <= done_nxt_s;
      pass_r       <= pass_nxt_s;
      locked_r     <= locked_nxt_s;
    end
  end

`ifdef SEQ_UNLOCK_LOCKOUT_EN
  // Fail counter deliberately survives RESET so a reset cannot bypass the lockout
  always_ff @(posedge clk) begin
    fail_cnt_r <= fail_cnt_nxt_s;
  end
`endif

  assign code_ready = code_ready_r;
  assign det_in     = det_in_r;
  assign det_rst_n  = det_rst_n_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign locked     = locked_r;
  assign fail_cnt   = fail_cnt_r;

endmodule

// File: tb/tb_seq_unlock_ctrl.sv
// Directed self-checking bench for seq_unlock_ctrl with a behavioural serial detector model.
module tb_seq_unlock_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic        code_valid;
  logic [23:0] code_data;
  logic        code_ready, det_in, det_rst_n, det_out, done, pass, locked;
  logic [1:0]  fail_cnt;
  logic        det_force;
  logic [23:0] hist;
  logic [23:0] secret = 24'hA5C3E1;
  logic [23:0] wrong  = 24'hA5C3E0;
  int total = 0;
  int bad   = 0;

  seq_unlock_ctrl dut (
    .clk(clk), .RESET(RESET), .code_valid(code_valid), .code_data(code_data),
    .code_ready(code_ready), .det_in(det_in), .det_rst_n(det_rst_n), .det_out(det_out),
    .done(done), .pass(pass), .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Detector model: last 24 serial bits compared to the secret; det_force injects a spurious match
  always @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) hist <= 24'h0;
    else            hist <= {hist[22:0], det_in};
  end
  assign det_out = (hist == secret) | det_force;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    RESET = 1'b1; code_valid = 1'b0; code_data = 24'h0; det_force = 1'b0;
    #1 RESET = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (code_ready !== 1'b0) begin bad++; $display("FAIL reset code_ready: got %b want 0", code_ready); end
    total++; if (det_in !== 1'b0) begin bad++; $display("FAIL reset det_in: got %b want 0", det_in); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset pass: got %b want 0", pass); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset locked: got %b want 0", locked); end
    total++; if (det_rst_n !== 1'b0) begin bad++; $display("FAIL reset det_rst_n: got %b want 0", det_rst_n); end
`ifndef SEQ_UNLOCK_LOCKOUT_EN
    total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL reset fail_cnt: got %0d want 0", fail_cnt); end
`endif
    RESET = 1'b1;
    @(negedge clk);
    total++; if (code_ready !== 1'b1) begin bad++; $display("FAIL reset release code_ready: got %b want 1", code_ready); end
    total++; if (det_rst_n !== 1'b1) begin bad++; $display("FAIL reset release det_rst_n: got %b want 1", det_rst_n); end
  endtask

  // One attempt with cycle-exact checks; k counts cycles after the accepting edge T
  task automatic run_attempt(input string name, input logic [23:0] code, input logic exp_pass,
                             input logic [1:0] exp_cnt, input bit spur, input bit exp_lock);
    int   dk;
    logic exp_din;
    dk = (code == secret) ? 27 : 28;
    @(negedge clk);
    total++; if (code_ready !== 1'b1) begin bad++; $display("FAIL %s ready_before: got %b want 1", name, code_ready); end
    code_valid = 1'b1; code_data = code;
    @(posedge clk);
    #1 code_valid = 1'b0; code_data = ~code;
    for (int k = 1; k <= dk + 1; k++) begin
      @(negedge clk);
      exp_din = (k >= 2 && k <= 25) ? code[25-k] : 1'b0;
      total++; if (det_rst_n !== (k != 1)) begin bad++; $display("FAIL %s det_rst_n k=%0d: got %b want %b", name, k, det_rst_n, (k != 1)); end
      total++; if (det_in !== exp_din) begin bad++; $display("FAIL %s det_in k=%0d: got %b want %b", name, k, det_in, exp_din); end
      total++; if (done !== (k == dk)) begin bad++; $display("FAIL %s done k=%0d: got %b want %b", name, k, done, (k == dk)); end
      if (k == dk) begin
        total++; if (pass !== exp_pass) begin bad++; $display("FAIL %s pass: got %b want %b", name, pass, exp_pass); end
        total++; if (fail_cnt !== exp_cnt) begin bad++; $display("FAIL %s fail_cnt: got %0d want %0d", name, fail_cnt, exp_cnt); end
      end
      if (k == dk + 1) begin
        total++; if (code_ready !== !exp_lock) begin bad++; $display("FAIL %s ready_after: got %b want %b", name, code_ready, !exp_lock); end
        total++; if (locked !== exp_lock) begin bad++; $display("FAIL %s locked_after: got %b want %b", name, locked, exp_lock); end
      end
      if (spur) det_force = (k == 10);
    end
    det_force = 1'b0;
  endtask

  task automatic test_pass();
    run_attempt("pass", secret, 1'b1, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_fail();
    run_attempt("fail", wrong, 1'b0, 2'd1, 1'b0, 1'b0);
  endtask

  task automatic test_two_fails_then_pass();
    run_attempt("tfp_clear", secret, 1'b1, 2'd0, 1'b0, 1'b0);
    run_attempt("tfp_fail1", wrong, 1'b0, 2'd1, 1'b0, 1'b0);
    run_attempt("tfp_fail2", wrong, 1'b0, 2'd2, 1'b0, 1'b0);
    run_attempt("tfp_pass", secret, 1'b1, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_lockout();
    run_attempt("lk_fail1", wrong, 1'b0, 2'd1, 1'b0, 1'b0);
    run_attempt("lk_fail2", wrong, 1'b0, 2'd2, 1'b0, 1'b0);
`ifdef SEQ_UNLOCK_LOCKOUT_EN
    run_attempt("lk_fail3", wrong, 1'b0, 2'd3, 1'b0, 1'b1);
    code_data = secret;
    for (int k = 30; k <= 290; k++) begin
      @(negedge clk);
      total++; if (locked !== (k <= 284)) begin bad++; $display("FAIL lockout locked k=%0d: got %b want %b", k, locked, (k <= 284)); end
      total++; if (code_ready !== (k >= 285)) begin bad++; $display("FAIL lockout code_ready k=%0d: got %b want %b", k, code_ready, (k >= 285)); end
      total++; if (det_rst_n !== 1'b1) begin bad++; $display("FAIL lockout det_rst_n k=%0d: got %b want 1", k, det_rst_n); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL lockout done k=%0d: got %b want 0", k, done); end
      if (k == 285) begin
        total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL lockout fail_cnt_after: got %0d want 0", fail_cnt); end
      end
      code_valid = (k == 40 || k == 41 || k == 150 || k == 284);
    end
    code_valid = 1'b0;
    run_attempt("lk_after", secret, 1'b1, 2'd0, 1'b0, 1'b0);
`else
    run_attempt("sat_fail3", wrong, 1'b0, 2'd3, 1'b0, 1'b0);
    run_attempt("sat_fail4", wrong, 1'b0, 2'd3, 1'b0, 1'b0);
    run_attempt("sat_pass", secret, 1'b1, 2'd0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_keep;
    run_attempt("rm_fail", wrong, 1'b0, 2'd1, 1'b0, 1'b0);
`ifdef SEQ_UNLOCK_LOCKOUT_EN
    exp_keep = 2'd1;
`else
    exp_keep = 2'd0;
`endif
    @(negedge clk);
    code_valid = 1'b1; code_data = secret;
    @(posedge clk);
    #1 code_valid = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;
    #1;
    total++; if (det_rst_n !== 1'b0) begin bad++; $display("FAIL reset_mid det_rst_n: got %b want 0", det_rst_n); end
    total++; if (det_in !== 1'b0) begin bad++; $display("FAIL reset_mid det_in: got %b want 0", det_in); end
    total++; if (code_ready !== 1'b0) begin bad++; $display("FAIL reset_mid code_ready: got %b want 0", code_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_mid done_low: got %b want 0", done); end
      total++; if (det_rst_n !== 1'b0) begin bad++; $display("FAIL reset_mid det_rst_n_low: got %b want 0", det_rst_n); end
    end
    total++; if (fail_cnt !== exp_keep) begin bad++; $display("FAIL reset_mid fail_cnt: got %0d want %0d", fail_cnt, exp_keep); end
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_mid done_after: got %b want 0", done); end
      total++; if (code_ready !== 1'b1) begin bad++; $display("FAIL reset_mid ready_after: got %b want 1", code_ready); end
    end
    total++; if (fail_cnt !== exp_keep) begin bad++; $display("FAIL reset_mid fail_cnt_kept: got %0d want %0d", fail_cnt, exp_keep); end
    run_attempt("rm_next", secret, 1'b1, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_spurious();
    run_attempt("spurious", secret, 1'b0, 2'd1, 1'b1, 1'b0);
  endtask

  initial begin
    det_force = 1'b0;
    test_reset();
    test_pass();
    test_fail();
    test_two_fails_then_pass();
    test_lockout();
    test_reset_mid();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_unlock_ctrl.md
# seq_unlock_ctrl

Sequencing controller for the serial sequence detector. It accepts a parallel candidate code word over a valid/ready handshake, clears the detector, and shifts the word into it MSB first. It then watches the detector's match output and reports pass or fail, counting consecutive failures. Optionally, it locks out further attempts after too many failures. It sits between the security front-end (code source) and the detector instance.

## Interface
- CODE_W, 24, code length in bits; equals the detector's sequence length.
- MAX_FAIL, 3, consecutive failures that trigger lockout (≥1).
- LOCK_CYCLES, 256, lockout duration in clk cycles (≥2).
- RESP_WIN, 2, cycles det_out is sampled after the last bit (≥1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- code_valid  in  1  candidate code present.
- code_data  in  CODE_W  candidate code, MSB sent first.
- code_ready  out  1  controller can accept a code.
- det_in  out  1  serial bit to detector `in`.
- det_rst_n  out  1  active-low reset to the detector.
- det_out  in  1  detector match output.
- done  out  1  one-cycle pulse: attempt finished.
- pass  out  1  valid with done: 1 = match, 0 = fail.
- locked  out  1  lockout active.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count.

## Operation
- States:
  - IDLE: code_ready=1. Handshake on code_valid&&code_ready loads the shift register and the bit counter (CODE_W-1), then goes to CLEAR.
  - CLEAR: det_rst_n=0 for exactly 1 cycle, then goes to SHIFT.
  - SHIFT: det_in = shift-register MSB. The register shifts left each cycle. Leaves after CODE_W cycles for WAIT with the window counter = RESP_WIN-1.
  - WAIT: samples det_out each cycle. If det_out=1, goes to REPORT with pass=1. When the window counter reaches 0 with no match, goes to REPORT with pass=0.
  - REPORT: done=1 and pass valid for one cycle.
    - Pass clears fail_cnt and returns to IDLE.
    - Fail increments fail_cnt (saturating at MAX_FAIL). If the new count equals MAX_FAIL, goes to LOCKOUT; otherwise goes to IDLE.
  - LOCKOUT: locked=1 and code_ready=0. Counts LOCK_CYCLES cycles, then clears fail_cnt and goes to IDLE.
- A det_out=1 seen during SHIFT sets a sticky spurious flag. That flag forces pass=0 for the current attempt.
- det_in=0 in all states except SHIFT.
- det_rst_n = RESET AND (state != CLEAR). Driving det_rst_n from RESET also releases a detector that is stuck in its deadlock trap.
- code_valid is ignored outside IDLE. The code_data that is not accepted is not buffered.

## Timing
- Reset (RESET=0, asynchronous):
  - Outputs and state: state=IDLE, code_ready=0, det_in=0, done=0, pass=0, locked=0, fail_cnt=0, det_rst_n=0.
  - First rising edge after release: code_ready=1.
- Attempt timeline, with the handshake accepted at edge T:
  - Cycle T+1 is CLEAR.
  - Bits b[CODE_W-1]..b[0] are driven in cycles T+2..T+CODE_W+1.
  - On a good code the detector asserts det_out in cycle T+CODE_W+2.
  - Pass: done pulses in cycle T+CODE_W+3.
  - Fail: done pulses in cycle T+CODE_W+2+RESP_WIN.
- Back-to-back: code_ready returns to 1 the cycle after REPORT. Minimum attempt period is CODE_W+4 cycles.
- Lockout: locked=1 from the cycle after the failing REPORT, for LOCK_CYCLES cycles. code_ready rises the cycle after locked falls.
- Reset mid-attempt (any state, including LOCKOUT):
  - Immediate abort.
  - No done pulse.
  - fail_cnt cleared only when the lockout feature is compiled out. With it compiled in, fail_cnt is held in a register not cleared by RESET; it is cleared only by pass or lockout expiry. This prevents a reset from bypassing the lockout.

## Configuration
- SEQ_UNLOCK_LOCKOUT_EN defined:
  - LOCKOUT state exists.
  - The lockout fail counter is retained across RESET, as described under Timing.
- Not defined:
  - The LOCKOUT state is absent.
  - locked is tied to 0.
  - fail_cnt saturates at MAX_FAIL and is reset by RESET.
  - The controller always returns to IDLE after REPORT.

## Test plan
- Correct code 24'hxxxxxx matching the detector, with a behavioural detector model -> det_rst_n low at T+1; bits MSB first at T+2..T+25; done=1, pass=1 at T+27; fail_cnt=0.
- Wrong code (correct code with bit 0 flipped) -> done at T+28 (RESP_WIN=2), pass=0, fail_cnt=1.
- Three consecutive wrong codes (defaults, macro defined):
  - locked=1 for 256 cycles and code_ready=0 throughout.
  - code_valid pulses during lockout are ignored.
  - Then fail_cnt=0 and code_ready=1.
- Two fails, then one correct code -> pass=1, fail_cnt returns from 2 to 0, no lockout.
- RESET pulse at cycle T+10 of an attempt:
  - No done pulse.
  - det_rst_n=0 while RESET=0.
  - Next attempt runs the full timeline.
  - With the macro defined, fail_cnt is preserved.
- det_out forced to 1 during SHIFT, then a correct response -> pass=0, fail_cnt incremented.
